// File: rtl/pal_sync_generator.sv
// PAL 625-line interlaced H/V timing generator with pixel enable and genlock resync.
// Every registered output is decoded from the next-state counters, so all outputs describe the same pixel.
module pal_sync_generator #(
    parameter int unsigned H_TOTAL        = 864,
    parameter int unsigned H_SYNC         = 64,
    parameter int unsigned H_ACTIVE_START = 132,
    parameter int unsigned H_ACTIVE       = 720,
    parameter int unsigned V_LINES        = 313,
    parameter int unsigned V_SYNC_LINES   = 3,
    parameter int unsigned V_ACTIVE_START = 23,
    parameter int unsigned V_ACTIVE       = 287,
    parameter int unsigned H_BITS         = 10,
    parameter int unsigned V_BITS         = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              resync,
    output logic              hSync,
    output logic              vSync,
    output logic              field,
    output logic [H_BITS-1:0] hCount,
    output logic [V_BITS-1:0] vCount,
    output logic              activeVideo,
    output logic              frameStart
);

    localparam logic [H_BITS-1:0] H_LAST      = H_BITS'(H_TOTAL - 1);
    localparam logic [H_BITS-1:0] H_SYNC_W    = H_BITS'(H_SYNC);
    localparam logic [H_BITS-1:0] H_HALF      = H_BITS'(H_TOTAL / 2);
    localparam logic [H_BITS:0]   H_ACT_FIRST = (H_BITS+1)'(H_ACTIVE_START);
    localparam logic [H_BITS:0]   H_ACT_END   = (H_BITS+1)'(H_ACTIVE_START + H_ACTIVE);
    localparam logic [V_BITS-1:0] V_LAST0     = V_BITS'(V_LINES - 1);
    localparam logic [V_BITS-1:0] V_LAST1     = V_BITS'(V_LINES - 2);
    localparam logic [V_BITS-1:0] V_SYNC_W    = V_BITS'(V_SYNC_LINES);
    localparam logic [V_BITS:0]   V_ACT_FIRST = (V_BITS+1)'(V_ACTIVE_START);
    localparam logic [V_BITS:0]   V_ACT_END   = (V_BITS+1)'(V_ACTIVE_START + V_ACTIVE);

    if (H_TOTAL > (1 << H_BITS)) begin : gBadHTotal
        $error("H_TOTAL does not fit in H_BITS");
    end
    if (H_SYNC >= H_TOTAL || H_ACTIVE_START + H_ACTIVE > H_TOTAL) begin : gBadHTiming
        $error("horizontal timing exceeds H_TOTAL");
    end
    if (V_LINES > (1 << V_BITS) || V_LINES < 2) begin : gBadVLines
        $error("V_LINES does not fit in V_BITS");
    end
    if (V_SYNC_LINES >= V_LINES - 1 || V_ACTIVE_START + V_ACTIVE > V_LINES - 1) begin : gBadVTiming
        $error("vertical timing exceeds the shorter field");
    end

    logic [H_BITS-1:0] r_hCount;
    logic [V_BITS-1:0] r_vCount;
    logic              r_field;
    logic              r_hSync;
    logic              r_vSync;
    logic              r_activeVideo;
    logic              r_frameStart;

    logic [H_BITS-1:0] w_hNext;
    logic [V_BITS-1:0] w_vNext;
    logic              w_fieldNext;
    logic              w_vSyncLowF0;
    logic              w_vSyncLowF1;
    logic              w_hSyncNext;
    logic              w_vSyncNext;
    logic              w_activeNext;
    logic              w_frameStartNext;

    always_comb begin
        w_hNext     = r_hCount;
        w_vNext     = r_vCount;
        w_fieldNext = r_field;
        if (resync) begin
            w_hNext     = '0;
            w_vNext     = '0;
            w_fieldNext = 1'b0;
        end else if (enable) begin
            if (r_hCount == H_LAST) begin
                w_hNext = '0;
                if (r_vCount == (r_field ? V_LAST1 : V_LAST0)) begin
                    w_vNext     = '0;
                    w_fieldNext = ~r_field;
                end else begin
                    w_vNext = r_vCount + 1'b1;
                end
            end else begin
                w_hNext = r_hCount + 1'b1;
            end
        end
    end

    // Field 1 shifts the broad vSync pulse by half a line to produce the interlace.
    always_comb begin
        w_hSyncNext      = (w_hNext >= H_SYNC_W);
        w_vSyncLowF0     = (w_vNext < V_SYNC_W);
        w_vSyncLowF1     = ((w_vNext == '0) && (w_hNext >= H_HALF))
                         || ((w_vNext != '0) && (w_vNext < V_SYNC_W))
                         || ((w_vNext == V_SYNC_W) && (w_hNext < H_HALF));
        w_vSyncNext      = ~(w_fieldNext ? w_vSyncLowF1 : w_vSyncLowF0);
        w_activeNext     = ({1'b0, w_hNext} >= H_ACT_FIRST) && ({1'b0, w_hNext} < H_ACT_END)
                         && ({1'b0, w_vNext} >= V_ACT_FIRST) && ({1'b0, w_vNext} < V_ACT_END);
        w_frameStartNext = (w_hNext == '0) && (w_vNext == '0) && !w_fieldNext;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hCount      <= '0;
            r_vCount      <= '0;
            r_field       <= 1'b0;
            r_hSync       <= 1'b0;
            r_vSync       <= 1'b0;
            r_activeVideo <= 1'b0;
            r_frameStart  <= 1'b1;
        end else begin
            r_hCount      <= w_hNext;
            r_vCount      <= w_vNext;
            r_field       <= w_fieldNext;
            r_hSync       <= w_hSyncNext;
            r_vSync       <= w_vSyncNext;
            r_activeVideo <= w_activeNext;
            r_frameStart  <= w_frameStartNext;
        end
    end

    assign hCount      = r_hCount;
    assign vCount      = r_vCount;
    assign field       = r_field;
    assign hSync       = r_hSync;
    assign vSync       = r_vSync;
    assign activeVideo = r_activeVideo;
    assign frameStart  = r_frameStart;

endmodule

// File: tb/tb_pal_sync_generator.sv
// Bench for pal_sync_generator: a shrunken-timing instance covers whole frames, a default instance covers real PAL line timing.
module tb_pal_sync_generator;

    localparam int S_HT = 40, S_HS = 4, S_HAS = 8, S_HA = 24;
    localparam int S_VL = 13, S_VS = 3, S_VAS = 3, S_VA = 8;
    localparam int F_HT = 864, F_HS = 64, F_HAS = 132, F_HA = 720;
    localparam int F_VL = 313, F_VS = 3, F_VAS = 23, F_VA = 287;
    localparam int WINDOW = 2000;

    typedef struct {
        int h;
        int v;
        int f;
    } posT;

    logic clock = 1'b0;
    logic reset, enable, resyncS, resyncF;

    logic       sHSync, sVSync, sField, sActive, sFrame;
    logic [5:0] sHCount;
    logic [3:0] sVCount;
    logic       fHSync, fVSync, fField, fActive, fFrame;
    logic [9:0] fHCount;
    logic [8:0] fVCount;

    int  errorCount = 0;
    int  checkCount = 0;
    posT mS, mF;

    bit statsOn = 1'b0;
    int statCycle, cntFs, cntF0, cntF1, cntAct, cntHsLowS, cntHsLowF, riseA, riseB;
    logic prevHs;

    pal_sync_generator #(
        .H_TOTAL(S_HT), .H_SYNC(S_HS), .H_ACTIVE_START(S_HAS), .H_ACTIVE(S_HA),
        .V_LINES(S_VL), .V_SYNC_LINES(S_VS), .V_ACTIVE_START(S_VAS), .V_ACTIVE(S_VA),
        .H_BITS(6), .V_BITS(4)
    ) dutSmall (
        .clock(clock), .reset(reset), .enable(enable), .resync(resyncS),
        .hSync(sHSync), .vSync(sVSync), .field(sField), .hCount(sHCount), .vCount(sVCount),
        .activeVideo(sActive), .frameStart(sFrame)
    );

    pal_sync_generator dutFull (
        .clock(clock), .reset(reset), .enable(enable), .resync(resyncF),
        .hSync(fHSync), .vSync(fVSync), .field(fField), .hCount(fHCount), .vCount(fVCount),
        .activeVideo(fActive), .frameStart(fFrame)
    );

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Position along the field in pixel clocks makes the interlaced vSync window a plain range test.
    function automatic logic [4:0] expectFlags(posT p, int ht, int hs, int has, int ha, int vs, int vas, int va);
        int   pos;
        logic vsLow, act;
        pos = p.v * ht + p.h;
        if (p.f == 0) vsLow = (pos < vs * ht);
        else          vsLow = (pos >= ht / 2) && (pos < vs * ht + ht / 2);
        act = (p.h >= has) && (p.h < has + ha) && (p.v >= vas) && (p.v < vas + va);
        return {p.h >= hs, !vsLow, 1'(p.f), act, (pos == 0) && (p.f == 0)};
    endfunction

    function automatic posT advance(posT p, bit rst, bit en, bit rs, int ht, int vl);
        posT n = p;
        if (rst || rs) begin
            n = '{0, 0, 0};
        end else if (en) begin
            n.h = p.h + 1;
            if (n.h == ht) begin
                n.h = 0;
                n.v = p.v + 1;
                if (n.v == vl - p.f) begin
                    n.v = 0;
                    n.f = 1 - p.f;
                end
            end
        end
        return n;
    endfunction

    task automatic checkBoth();
        checkOutput("small", {8'd0, sHSync, sVSync, sField, sActive, sFrame, 10'(sHCount), 9'(sVCount)},
                    {8'd0, expectFlags(mS, S_HT, S_HS, S_HAS, S_HA, S_VS, S_VAS, S_VA), 10'(mS.h), 9'(mS.v)});
        checkOutput("full", {8'd0, fHSync, fVSync, fField, fActive, fFrame, 10'(fHCount), 9'(fVCount)},
                    {8'd0, expectFlags(mF, F_HT, F_HS, F_HAS, F_HA, F_VS, F_VAS, F_VA), 10'(mF.h), 9'(mF.v)});
    endtask

    task automatic sampleStats();
        if (statsOn) begin
            if (sFrame) cntFs++;
            if (sField) cntF1++; else cntF0++;
            if (sActive) cntAct++;
            if (!sHSync) cntHsLowS++;
            if (!fHSync) cntHsLowF++;
            if (!prevHs && fHSync) begin
                if (riseA < 0) riseA = statCycle;
                else if (riseB < 0) riseB = statCycle;
            end
            prevHs = fHSync;
            statCycle++;
        end
    endtask

    task automatic stepCycle();
        @(posedge clock);
        mS = advance(mS, reset, enable, resyncS, S_HT, S_VL);
        mF = advance(mF, reset, enable, resyncF, F_HT, F_VL);
        #1;
        checkBoth();
        sampleStats();
    endtask

    task automatic applyStimulus(input bit en, input bit rsS, input bit rsF);
        enable  = en;
        resyncS = rsS;
        resyncF = rsF;
        stepCycle();
    endtask

    // Asserted between edges so the origin must appear without any clock.
    task automatic applyReset();
        #2;
        reset = 1'b1;
        #1;
        mS = '{0, 0, 0};
        mF = '{0, 0, 0};
        checkBoth();
        checkOutput("asyncOriginFrame", {31'd0, sFrame & fFrame}, 32'd1);
        #2;
        reset = 1'b0;
    endtask

    function automatic int hsLowIn(int n, int ht, int hs);
        return (n / ht) * hs + ((n % ht) < hs ? (n % ht) : hs);
    endfunction

    initial begin
        int i;
        reset   = 1'b1;
        enable  = 1'b1;
        resyncS = 1'b0;
        resyncF = 1'b0;
        mS = '{0, 0, 0};
        mF = '{0, 0, 0};
        #1;
        checkBoth();
        repeat (3) stepCycle();
        reset = 1'b0;

        statsOn = 1'b1;
        statCycle = 0; cntFs = 0; cntF0 = 0; cntF1 = 0; cntAct = 0;
        cntHsLowS = 0; cntHsLowF = 0; riseA = -1; riseB = -1; prevHs = fHSync;
        sampleStats();
        repeat (WINDOW - 1) applyStimulus(1'b1, 1'b0, 1'b0);
        statsOn = 1'b0;
        checkOutput("frameStartCount", cntFs, WINDOW / (S_HT * (2 * S_VL - 1)));
        checkOutput("field0Clocks", cntF0, 2 * S_HT * S_VL);
        checkOutput("field1Clocks", cntF1, 2 * S_HT * (S_VL - 1));
        checkOutput("activeClocks", cntAct, 2 * 2 * S_VA * S_HA);
        checkOutput("hSyncLowSmall", cntHsLowS, hsLowIn(WINDOW, S_HT, S_HS));
        checkOutput("hSyncLowFull", cntHsLowF, hsLowIn(WINDOW, F_HT, F_HS));
        checkOutput("hSyncFirstRise", riseA, F_HS);
        checkOutput("hSyncPeriod", riseB - riseA, F_HT);

        i = 0;
        while (mF.h != 500 && i < 2 * F_HT) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            i++;
        end
        checkOutput("reachH500", {31'd0, mF.h == 500}, 32'd1);
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("frozenH", 32'(fHCount), 32'd500);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("resumeH", 32'(fHCount), 32'd501);

        i = 0;
        while (!(mS.f == 1 && mS.v == 1 && mS.h == 30) && i < 3 * S_HT * 2 * S_VL) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            i++;
        end
        checkOutput("reachResyncPoint", {31'd0, mS.f == 1 && mS.v == 1 && mS.h == 30}, 32'd1);
        checkOutput("inVSync", {31'd0, sVSync}, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("resyncOrigin", {29'd0, sFrame, sField, sVSync}, {29'd0, 3'b100});

        for (int k = 0; k < 25000; k++) begin
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 2999) == 0,
                          $urandom_range(0, 19999) == 0);
        end

        applyReset();
        repeat (50) applyStimulus(1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
